// File: rtl/alu_issue_ctrl_if.sv
// Decode, register-file and ALU signals of the issue controller.
// master: environment side (decode, register file, ALU); slave: controller side.
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
// the source holds in_valid and all in_* fields stable until that edge.
interface alu_issue_ctrl_if #(
  parameter int DW  = 16,
  parameter int RAW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic [RAW-1:0] in_rdest;
  logic [RAW-1:0] in_rsrc;
  logic           in_use_imm;
  logic [DW-1:0]  in_imm;

  logic [RAW-1:0] rf_raddr_a;
  logic [RAW-1:0] rf_raddr_b;
  logic [DW-1:0]  rf_rdata_a;
  logic [DW-1:0]  rf_rdata_b;
  logic           rf_we;
  logic [RAW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;

  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [3:0]     alu_opcode;
  logic           alu_cin;
  logic [DW-1:0]  alu_c;
  logic [4:0]     alu_flags;

  modport master (
    output in_valid, in_op, in_rdest, in_rsrc, in_use_imm, in_imm,
    input  in_ready,
    input  rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    output rf_rdata_a, rf_rdata_b,
    input  alu_a, alu_b, alu_opcode, alu_cin,
    output alu_c, alu_flags
  );

  modport slave (
    input  in_valid, in_op, in_rdest, in_rsrc, in_use_imm, in_imm,
    output in_ready,
    output rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    input  rf_rdata_a, rf_rdata_b,
    output alu_a, alu_b, alu_opcode, alu_cin,
    input  alu_c, alu_flags
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue sequencer for the 16-bit ALU: IDLE -> READ -> EXEC -> WB.
// Owns the PSR and the retired-instruction counter; register file and ALU are external.
module alu_issue_ctrl #(
  parameter int DW  = 16,
  parameter int RAW = 4,
  parameter int CW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_issue_ctrl_if.slave      bus,
  output logic [4:0]           psr,
  output logic                 done,
  output logic                 err_illegal,
  output logic [CW-1:0]        retired,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_LSH  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADDU = 4'b0110;
  localparam logic [3:0] OP_ADDC = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_ASHU = 4'b1100;

  function automatic logic op_writes(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_LSH) ||
           (op == OP_ADD) || (op == OP_ADDU) || (op == OP_ADDC) || (op == OP_SUB) ||
           (op == OP_ASHU);
  endfunction

  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDU) || (op == OP_ADDC) ||
           (op == OP_SUB) || (op == OP_CMP);
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return op_writes(op) || (op == OP_NOP) || (op == OP_CMP);
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [RAW-1:0] rdest_q, rdest_d;
  logic [RAW-1:0] rsrc_q, rsrc_d;
  logic           use_imm_q, use_imm_d;
  logic [DW-1:0]  imm_q, imm_d;
  logic [DW-1:0]  res_q, res_d;
  logic [4:0]     flags_q, flags_d;
  logic [4:0]     psr_q, psr_d;
  logic [CW-1:0]  retired_q, retired_d;
  logic [DW-1:0]  src_opnd;
  logic           wb_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      psr_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rdest_q   <= rdest_d;
      rsrc_q    <= rsrc_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      psr_q     <= psr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    rdest_d        = rdest_q;
    rsrc_d         = rsrc_q;
    use_imm_d      = use_imm_q;
    imm_d          = imm_q;
    res_d          = res_q;
    flags_d        = flags_q;
    psr_d          = psr_q;
    retired_d      = retired_q;
    src_opnd       = use_imm_q ? imm_q : bus.rf_rdata_b;
    wb_write       = op_writes(op_q);
    bus.in_ready   = 1'b0;
    bus.rf_raddr_a = '0;
    bus.rf_raddr_b = '0;
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = '0;
    bus.rf_wdata   = '0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_opcode = '0;
    done           = 1'b0;
    err_illegal    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          op_d      = bus.in_op;
          rdest_d   = bus.in_rdest;
          rsrc_d    = bus.in_rsrc;
          use_imm_d = bus.in_use_imm;
          imm_d     = bus.in_imm;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        bus.rf_raddr_a = rdest_q;
        bus.rf_raddr_b = rsrc_q;
        state_d        = S_EXEC;
      end
      S_EXEC: begin
        // Shifts take the shift amount on A and the value being shifted on B.
        if ((op_q == OP_LSH) || (op_q == OP_ASHU)) begin
          bus.alu_a = src_opnd;
          bus.alu_b = bus.rf_rdata_a;
        end else begin
          bus.alu_a = bus.rf_rdata_a;
          bus.alu_b = src_opnd;
        end
        bus.alu_opcode = op_q;
        res_d          = bus.alu_c;
        flags_d        = bus.alu_flags;
        state_d        = S_WB;
      end
      S_WB: begin
        bus.rf_we = wb_write;
        if (wb_write) begin
          bus.rf_waddr = rdest_q;
          bus.rf_wdata = res_q;
        end
        if (op_sets_flags(op_q)) begin
          psr_d = flags_q;
        end
        done        = 1'b1;
        err_illegal = !op_legal(op_q);
        retired_d   = retired_q + CW'(1);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ADDC sees the carry left by the last flag-updating instruction.
  assign bus.alu_cin = psr_q[3];
  assign psr         = psr_q;
  assign retired     = retired_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural register file and ALU around the DUT, an
// instruction-level reference model, and a write-back scoreboard.
module tb_alu_issue_ctrl;
  localparam int DW  = 16;
  localparam int RAW = 4;
  localparam int CW  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DW(DW), .RAW(RAW)) bus ();
  logic [4:0]    psr;
  logic          done;
  logic          err_illegal;
  logic [CW-1:0] retired;
  logic [1:0]    state_dbg;

  alu_issue_ctrl #(.DW(DW), .RAW(RAW), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .psr         (psr),
    .done        (done),
    .err_illegal (err_illegal),
    .retired     (retired),
    .state_dbg   (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- ALU behaviour: returns {Z,C,F,N,L, result} ----------------
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, f, l;
    int          amt;
    w = '0; r = '0; c = 1'b0; f = 1'b0; l = 1'b0;
    amt = $signed(a[4:0]);
    case (op)
      4'd1:  r = a & b;
      4'd2:  r = a | b;
      4'd3:  r = a ^ b;
      4'd4:  r = (amt >= 0) ? (b << amt) : (b >> (-amt));
      4'd12: r = (amt >= 0) ? (b << amt) : 16'($signed(b) >>> (-amt));
      4'd5, 4'd6, 4'd7: begin
        w = {1'b0, a} + {1'b0, b} + ((op == 4'd7) ? {16'd0, cin} : 17'd0);
        r = w[15:0];
        c = w[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd9, 4'd11: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[15:0];
        c = w[16];
        f = (a[15] != b[15]) && (r[15] != a[15]);
        l = (a < b);
      end
      default: r = '0;
    endcase
    return {(r == 16'd0), c, f, r[15], l, r};
  endfunction

  always_comb {bus.alu_flags, bus.alu_c} = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin);

  // ---------------- register file (1-cycle read latency) ----------------
  logic [DW-1:0]  rf_mem [16];
  logic           poke_en = 1'b0;
  logic [RAW-1:0] poke_a  = '0;
  logic [DW-1:0]  poke_d  = '0;

  always @(posedge clk) begin
    bus.rf_rdata_a <= rf_mem[bus.rf_raddr_a];
    bus.rf_rdata_b <= rf_mem[bus.rf_raddr_b];
    if (poke_en) rf_mem[poke_a] <= poke_d;
    else if (bus.rf_we) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_rf [16];
  logic [4:0]    ref_psr = '0;
  logic [CW-1:0] ref_retired = '0;
  logic [19:0]   exp_q[$];

  task automatic ref_step(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input logic ui, input logic [15:0] imm,
                          output logic [15:0] a, output logic [15:0] b, output logic cin,
                          output logic wr, output logic ill);
    logic [15:0] d, s;
    logic [20:0] r;
    logic        shift, upd;
    d     = ref_rf[rd];
    s     = ui ? imm : ref_rf[rs];
    shift = (op == 4'd4) || (op == 4'd12);
    a     = shift ? s : d;
    b     = shift ? d : s;
    cin   = ref_psr[3];
    r     = alu_fn(op, a, b, cin);
    wr    = op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12};
    upd   = op inside {4'd5, 4'd6, 4'd7, 4'd9, 4'd11};
    ill   = op inside {4'd8, 4'd10, 4'd13, 4'd14, 4'd15};
    if (wr) begin
      exp_q.push_back({rd, r[15:0]});
      ref_rf[rd] = r[15:0];
    end
    if (upd) ref_psr = r[20:16];
    ref_retired = ref_retired + CW'(1);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.rf_we) begin
      if (exp_q.size() == 0) check("wb_unexpected", {12'd0, bus.rf_waddr, bus.rf_wdata}, 32'd0);
      else check("wb_data", {12'd0, bus.rf_waddr, bus.rf_wdata}, {12'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [3:0] i, input logic [15:0] v);
    poke_en = 1'b1; poke_a = i; poke_d = v; ref_rf[i] = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic drive_fields(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                              input logic ui, input logic [15:0] imm);
    bus.in_op = op; bus.in_rdest = rd; bus.in_rsrc = rs; bus.in_use_imm = ui; bus.in_imm = imm;
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic ui, input logic [15:0] imm);
    logic [15:0] a, b;
    logic        cin, wr, ill;
    wait_ready();
    ref_step(op, rd, rs, ui, imm, a, b, cin, wr, ill);
    drive_fields(op, rd, rs, ui, imm);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("read_addr", {23'd0, bus.in_ready, bus.rf_raddr_a, bus.rf_raddr_b}, {23'd0, 1'b0, rd, rs});
    @(negedge clk);
    check("exec_ab", {bus.alu_a, bus.alu_b}, {a, b});
    check("exec_op", {27'd0, bus.alu_opcode, bus.alu_cin}, {27'd0, op, cin});
    @(negedge clk);
    check("wb_ctl", {28'd0, bus.rf_we, done, err_illegal, bus.in_ready}, {28'd0, wr, 1'b1, ill, 1'b0});
    @(negedge clk);
    check("post", {9'd0, psr, retired, bus.in_ready, done}, {9'd0, ref_psr, ref_retired, 1'b1, 1'b0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a, b;
    logic        cin, wr, ill;
    int          acc;
    int          acc_at [2];

    reset = 1'b1;
    bus.in_valid = 1'b0;
    drive_fields(4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    check("rst_ctl", {26'd0, bus.in_ready, bus.rf_we, done, err_illegal, bus.alu_cin, 1'b0},
          {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("rst_psr_ret", {11'd0, psr, retired}, 32'd0);
    check("rst_alu", {bus.alu_a, bus.alu_b}, 32'd0);
    check("rst_addr", {8'd0, bus.alu_opcode, bus.rf_raddr_a, bus.rf_raddr_b, bus.rf_waddr, bus.rf_wdata},
          32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) poke(4'(i), 16'($urandom_range(0, 65535)));

    // signed overflow on ADD
    poke(4'd1, 16'h7FFF); poke(4'd2, 16'h0001);
    issue(4'b0101, 4'd1, 4'd2, 1'b0, 16'd0);
    check("add_r1", {16'd0, rf_mem[1]}, 32'h8000);
    check("add_flags", {28'd0, psr[4:1]}, {28'd0, 4'b0011});
    check("add_retired", {16'd0, retired}, 32'd1);

    poke(4'd3, 16'hFFFE);
    issue(4'b1011, 4'd3, 4'd0, 1'b1, 16'h0001);
    check("cmp_keep_r3", {16'd0, rf_mem[3]}, 32'hFFFE);

    // carry chain ADDU -> ADDC
    poke(4'd4, 16'hFFFF);
    issue(4'b0110, 4'd4, 4'd0, 1'b1, 16'h0001);
    check("addu_r4", {16'd0, rf_mem[4]}, 32'h0000);
    check("addu_c", {31'd0, psr[3]}, 32'd1);
    poke(4'd5, 16'h0001);
    issue(4'b0111, 4'd5, 4'd0, 1'b1, 16'h0000);
    check("addc_r5", {16'd0, rf_mem[5]}, 32'h0002);

    poke(4'd6, 16'h8001);
    issue(4'b0100, 4'd6, 4'd0, 1'b1, 16'hFFFF);
    check("lsh_r6", {16'd0, rf_mem[6]}, 32'h4000);

    issue(4'b1111, 4'd2, 4'd3, 1'b0, 16'd0);
    issue(4'b0101, 4'd9, 4'd9, 1'b0, 16'd0);

    // reset during EXEC of a SUB: nothing written, state cleared
    wait_ready();
    drive_fields(4'b1001, 4'd7, 4'd8, 1'b0, 16'd0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_psr = '0;
    ref_retired = '0;
    check("abort_ctl", {29'd0, bus.rf_we, bus.in_ready, done}, {29'd0, 1'b0, 1'b1, 1'b0});
    check("abort_psr_ret", {11'd0, psr, retired}, 32'd0);
    check("abort_alu", {bus.alu_a, bus.alu_b}, 32'd0);

    // in_valid held for 8 cycles, two instructions
    ref_step(4'b0101, 4'd7, 4'd8, 1'b0, 16'd0, a, b, cin, wr, ill);
    ref_step(4'b0011, 4'd10, 4'd0, 1'b1, 16'h5A5A, a, b, cin, wr, ill);
    drive_fields(4'b0101, 4'd7, 4'd8, 1'b0, 16'd0);
    bus.in_valid = 1'b1;
    acc = 0;
    acc_at[0] = 0; acc_at[1] = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus.in_valid && bus.in_ready) begin
        if (acc < 2) acc_at[acc] = cyc;
        acc++;
      end
      @(negedge clk);
      if (acc == 1) drive_fields(4'b0011, 4'd10, 4'd0, 1'b1, 16'h5A5A);
    end
    bus.in_valid = 1'b0;
    check("b2b_count", 32'(acc), 32'd2);
    check("b2b_gap", 32'(acc_at[1] - acc_at[0]), 32'd4);
    check("b2b_post", {11'd0, psr, retired}, {11'd0, ref_psr, ref_retired});

    // randomized instructions, including undefined opcodes
    for (int n = 0; n < 40; n++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) check("rf_final", {16'd0, rf_mem[i]}, {16'd0, ref_rf[i]});
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle sequencer that owns the 16-bit ALU (4-bit opcode, 5-bit Flags {Z,C,F,N,L} = bits [4:0]).
- Accepts one decoded instruction at a time over a valid/ready handshake, then:
  - reads operands from the external register file,
  - drives the ALU,
  - writes the result back,
  - updates the processor status register (PSR) according to per-opcode flag rules.
- Sits between decode and the register file / ALU pair.

Parameters:
- DW, 16, datapath width (ALU operand/result width)
- RAW, 4, register-file address width (16 registers)
- CW, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept (high only in IDLE)
- in_op  in  4  opcode: NOP 0000, AND 0001, OR 0010, XOR 0011, LSH 0100, ADD 0101, ADDU 0110, ADDC 0111, SUB 1001, CMP 1011, ASHU 1100
- in_rdest  in  RAW  destination / first-operand register
- in_rsrc  in  RAW  source register
- in_use_imm  in  1  1: source operand = in_imm instead of R[in_rsrc]
- in_imm  in  DW  immediate source operand
- rf_raddr_a  out  RAW  read port A address (Rdest)
- rf_raddr_b  out  RAW  read port B address (Rsrc)
- rf_rdata_a  in  DW  port A data, valid one cycle after address
- rf_rdata_b  in  DW  port B data, valid one cycle after address
- rf_we  out  1  register-file write enable
- rf_waddr  out  RAW  write address
- rf_wdata  out  DW  write data
- alu_a  out  DW  ALU operand A
- alu_b  out  DW  ALU operand B
- alu_opcode  out  4  ALU opcode
- alu_cin  out  1  carry-in for ADDC, equal to psr[3]
- alu_c  in  DW  ALU result (combinational)
- alu_flags  in  5  ALU flags (combinational)
- psr  out  5  registered status flags {Z,C,F,N,L}
- done  out  1  one-cycle pulse when an instruction retires
- err_illegal  out  1  one-cycle pulse in WB for an undefined opcode
- retired  out  CW  retired-instruction count

Behaviour:
- Reset values:
  - FSM = IDLE; in_ready = 1.
  - rf_we, done, err_illegal = 0.
  - psr = 5'b00000; retired = 0.
  - All address/data/ALU outputs = 0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. Fixed 4 cycles per instruction; no back-to-back overlap.
- IDLE:
  - When in_valid && in_ready: latch op, rdest, rsrc, use_imm and imm; go to READ.
  - in_valid while not in IDLE is ignored; the source must hold it until in_ready.
- READ:
  - rf_raddr_a = rdest; rf_raddr_b = rsrc.
  - Go to EXEC.
- EXEC:
  - Source operand S = use_imm ? imm : rf_rdata_b; D = rf_rdata_a.
  - Operand mapping:
    - Shift ops (LSH, ASHU): alu_a = S (signed shift amount), alu_b = D.
    - All other ops: alu_a = D, alu_b = S.
  - alu_opcode = latched op.
  - Register alu_c and alu_flags at end of cycle; go to WB.
  - alu_opcode/alu_a/alu_b are driven only in EXEC; 0 otherwise.
- WB, writeback:
  - rf_we = 1, rf_waddr = rdest, rf_wdata = registered result, for AND, OR, XOR, LSH, ADD, ADDU, ADDC, SUB, ASHU.
  - No write for NOP, CMP or illegal opcodes.
- WB, flag rules (psr updates at the end of WB):
  - ADD, ADDU, ADDC, SUB, CMP: psr <= registered flags.
  - Logic, shift, NOP and illegal opcodes: psr unchanged.
- WB, completion:
  - done = 1; retired increments, wrapping from 2^CW-1 to 0.
  - Illegal opcode: err_illegal = 1, otherwise treated as NOP (still counts as retired).
- alu_cin = psr[3] in every state. For ADDC it is sampled in EXEC, so the carry comes from the previous flag-updating instruction.
- Latency: accept at cycle t; rf_we/done at t+3; in_ready again at t+4; psr reflects the new flags from t+4.
- Reset mid-operation (any state): abort with no write and no flag update; pending instruction lost; all outputs return to reset values next cycle.
- Same-register operands (rdest == rsrc) are legal; both read ports return the same value.

Test Plan:
- Reset then ADD R1=0x7FFF, R2=0x0001 (rdest=1, rsrc=2) -> rf_we at t+3, R1 <= 0x8000, psr = {Z0,C0,F1,N1,L?} as reported by ALU, done pulse, retired=1, in_ready high at t+4.
- CMP rdest=3 (0xFFFE), use_imm=1, imm=0x0001 -> rf_we stays 0 all 4 cycles; psr updated from ALU flags; done pulse.
- ADDU 0xFFFF+0x0001 into R4, then ADDC R5=0x0001 + imm 0x0000 -> first gives R4=0x0000 with C=1; second has alu_cin=1 in EXEC and gives R5=0x0002.
- LSH rdest=6 (0x8001), imm=0xFFFF -> alu_a=0xFFFF, alu_b=0x8001; R6 <= 0x4000; psr unchanged from prior value.
- Opcode 1111 -> err_illegal and done pulse in WB; no rf_we; psr unchanged; retired increments. Then assert reset in EXEC of a following SUB -> no write, psr=0, retired=0, in_ready=1 next cycle.
- in_valid held high for 8 cycles with two different instructions -> exactly two accepts, 4 cycles apart; second captured only when in_ready=1.
